// File: rtl/tr_pkg.sv
// rtl/tr_pkg.sv - shared state encodings and default driver timing for the tracking/step path
package tr_pkg;

    localparam int WIDTH_WORK_DEF = 16;
    localparam int PULSE_W_CYC    = 100;
    localparam int DIR_SETUP_CYC  = 250;
    localparam int MIN_PERIOD_CYC = 500;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } step_state_t;

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - loadable down-counter; done flags the last cycle of the loaded interval
module step_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A load of N makes done high in the Nth cycle after the load edge.
    assign done = (count_q == WIDTH'(1));

endmodule

// File: rtl/step_pulse_gen.sv
// rtl/step_pulse_gen.sv - STEP/DIR pulse generator with DIR setup, pulse width and period floor
module step_pulse_gen
    import tr_pkg::*;
#(
    parameter int WIDTH_WORK = WIDTH_WORK_DEF,
    parameter int PULSE_W    = PULSE_W_CYC,
    parameter int DIR_SETUP  = DIR_SETUP_CYC,
    parameter int MIN_PERIOD = MIN_PERIOD_CYC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  dir_in,
    input  logic [WIDTH_WORK-1:0] period,
    output logic                  drv_step,
    output logic                  drv_dir,
    output logic                  busy,
    output logic                  step_done,
    output logic [WIDTH_WORK-1:0] position
);

    if (MIN_PERIOD <= PULSE_W) begin : g_bad_timing
        $error("step_pulse_gen: MIN_PERIOD must be greater than PULSE_W");
    end

    localparam logic [WIDTH_WORK-1:0] PULSE_V     = WIDTH_WORK'(PULSE_W);
    localparam logic [WIDTH_WORK-1:0] DIR_SETUP_V = WIDTH_WORK'(DIR_SETUP);
    localparam logic [WIDTH_WORK-1:0] MIN_PER_V   = WIDTH_WORK'(MIN_PERIOD);

    step_state_t           state_q, state_d;
    logic                  drv_step_q, drv_step_d;
    logic                  drv_dir_q, drv_dir_d;
    logic                  busy_q, busy_d;
    logic                  step_done_q, step_done_d;
    logic [WIDTH_WORK-1:0] position_q, position_d;
    logic [WIDTH_WORK-1:0] p_eff_q, p_eff_d;

    logic                  go;
    logic                  start;
    logic [WIDTH_WORK-1:0] p_clamped;
    logic                  tmr_load;
    logic [WIDTH_WORK-1:0] tmr_val;
    logic                  tmr_done;

    assign go        = enable && (period != '0);
    assign p_clamped = (period < MIN_PER_V) ? MIN_PER_V : period;
    // A new step is launched from IDLE or straight off the last LOW cycle.
    assign start     = go && ((state_q == IDLE) || ((state_q == LOW) && tmr_done));

    step_timer #(
        .WIDTH (WIDTH_WORK)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        drv_step_d  = drv_step_q;
        drv_dir_d   = drv_dir_q;
        busy_d      = busy_q;
        step_done_d = 1'b0;
        position_d  = position_q;
        p_eff_d     = p_eff_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
            end
            SETUP: begin
                if (tmr_done) begin
                    state_d    = HIGH;
                    drv_step_d = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_val    = PULSE_V;
                end
            end
            HIGH: begin
                if (tmr_done) begin
                    state_d    = LOW;
                    drv_step_d = 1'b0;
                    tmr_load   = 1'b1;
                    tmr_val    = p_eff_q - PULSE_V;
                end
            end
            LOW: begin
                if (tmr_done) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    step_done_d = 1'b1;
                    position_d  = drv_dir_q ? (position_q + 1'b1) : (position_q - 1'b1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Launch overrides the IDLE fall-through of the LOW branch; position update stays.
        if (start) begin
            p_eff_d  = p_clamped;
            busy_d   = 1'b1;
            tmr_load = 1'b1;
            if (dir_in != drv_dir_q) begin
                state_d    = SETUP;
                drv_dir_d  = dir_in;
                drv_step_d = 1'b0;
                tmr_val    = DIR_SETUP_V;
            end else begin
                state_d    = HIGH;
                drv_step_d = 1'b1;
                tmr_val    = PULSE_V;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            drv_step_q  <= 1'b0;
            drv_dir_q   <= 1'b0;
            busy_q      <= 1'b0;
            step_done_q <= 1'b0;
            position_q  <= '0;
            p_eff_q     <= '0;
        end else begin
            state_q     <= state_d;
            drv_step_q  <= drv_step_d;
            drv_dir_q   <= drv_dir_d;
            busy_q      <= busy_d;
            step_done_q <= step_done_d;
            position_q  <= position_d;
            p_eff_q     <= p_eff_d;
        end
    end

    assign drv_step  = drv_step_q;
    assign drv_dir   = drv_dir_q;
    assign busy      = busy_q;
    assign step_done = step_done_q;
    assign position  = position_q;

endmodule
